// File: rtl/pid_error_gen_if.sv
// Error-sample stream between pid_error_gen (producer) and the PID controller.
//   err        signed error sample (ERR_W bits)
//   err_valid  err holds an unconsumed sample
//   err_ready  consumer accepts err when err_valid & err_ready
interface pid_error_gen_if #(
  parameter int unsigned ERR_W = 9
) ();
  logic [ERR_W-1:0] err;
  logic             err_valid;
  logic             err_ready;

  modport master (output err, output err_valid, input err_ready);
  modport slave  (input err, input err_valid, output err_ready);
endinterface

// File: rtl/pid_error_gen.sv
// pid_error_gen: measures plant speed from a quadrature encoder over fixed
// sample windows and issues saturated signed error samples
// (setpoint - speed) on a valid/ready stream.
// Optional feature macro: PID_ERR_DEADBAND_EN (|err| <= DEADBAND forced to 0).
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   enc_a, enc_b  asynchronous encoder phases
//   setpoint      signed target edges per window, sampled in CALC
//   clr_ovr       synchronous clear of overrun
//   speed         signed edge count of the last completed window
//   overrun       sticky: an unconsumed sample was overwritten
//   err_if        master side of the error stream (err, err_valid, err_ready)
module pid_error_gen #(
  parameter int unsigned SAMPLE_DIV = 50,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned ERR_W      = 9,
  parameter int unsigned DEADBAND   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enc_a,
  input  logic                    enc_b,
  input  logic signed [ERR_W-1:0] setpoint,
  input  logic                    clr_ovr,
  output logic signed [CNT_W-1:0] speed,
  output logic                    overrun,
  pid_error_gen_if.master         err_if
);

  localparam int unsigned TMR_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned DW    = CNT_W + 1;

  localparam logic signed [DW-1:0] ERR_MAX = DW'((2 ** (ERR_W - 1)) - 1);
  localparam logic signed [DW-1:0] ERR_MIN = ~ERR_MAX;

  // Reject configurations the datapath cannot represent.
  if (SAMPLE_DIV < 4 || ERR_W > CNT_W || DEADBAND >= (2 ** (ERR_W - 1))) begin : g_bad_cfg
    $error("pid_error_gen: unsupported parameter set");
  end

  typedef enum logic {S_RUN, S_CALC} state_t;

  state_t                  state_q, state_d;
  logic                    a_s1_q, a_s2_q, a_prev_q;
  logic                    b_s1_q, b_s2_q, b_prev_q;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic signed [CNT_W-1:0] cnt_q, cnt_d;
  logic signed [CNT_W-1:0] speed_q, speed_d;
  logic signed [ERR_W-1:0] err_q, err_d;
  logic                    err_valid_q, err_valid_d;
  logic                    overrun_q, overrun_d;

  logic                    tick;
  logic signed [1:0]       step;
  logic signed [DW-1:0]    cnt_sum;
  logic signed [CNT_W-1:0] cnt_next;
  logic signed [DW-1:0]    diff;
  logic signed [DW-1:0]    diff_sat;
  logic                    ovr_set;

  // x4 quadrature decode; no change or an illegal double change gives 0.
  always_comb begin
    step = 2'sd0;
    unique case ({a_prev_q, b_prev_q, a_s2_q, b_s2_q})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step = 2'sd1;
      4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: step = -2'sd1;
      default:                                step = 2'sd0;
    endcase
  end

  // Saturating edge count; overflow shows as disagreeing top two bits.
  always_comb begin
    cnt_sum  = DW'(cnt_q) + DW'(step);
    cnt_next = cnt_sum[CNT_W-1:0];
    if (cnt_sum[DW-1] != cnt_sum[DW-2]) begin
      cnt_next = cnt_sum[DW-1] ? {1'b1, {(CNT_W-1){1'b0}}} : {1'b0, {(CNT_W-1){1'b1}}};
    end
  end

  assign tick = (timer_q == TMR_W'(SAMPLE_DIV - 1));

  // Error difference, clamp, optional deadband.
  always_comb begin
    diff     = DW'(setpoint) - DW'(speed_q);
    diff_sat = diff;
    if (diff > ERR_MAX) begin
      diff_sat = ERR_MAX;
    end else if (diff < ERR_MIN) begin
      diff_sat = ERR_MIN;
    end
`ifdef PID_ERR_DEADBAND_EN
    if ((diff_sat <= $signed(DW'(DEADBAND))) && (diff_sat >= -$signed(DW'(DEADBAND)))) begin
      diff_sat = '0;
    end
`endif
  end

  // Next-state: window timer, counter, FSM and output stream.
  always_comb begin
    state_d     = state_q;
    timer_d     = tick ? '0 : timer_q + TMR_W'(1);
    cnt_d       = tick ? '0 : cnt_next;
    speed_d     = tick ? cnt_next : speed_q;
    err_d       = err_q;
    err_valid_d = err_valid_q & ~err_if.err_ready;
    ovr_set     = 1'b0;

    unique case (state_q)
      S_RUN: begin
        if (tick) state_d = S_CALC;
      end
      S_CALC: begin
        err_d       = diff_sat[ERR_W-1:0];
        err_valid_d = 1'b1;
        ovr_set     = err_valid_q & ~err_if.err_ready;
        state_d     = S_RUN;
      end
      default: state_d = S_RUN;
    endcase

    // Set has priority over clear.
    overrun_d = (overrun_q & ~clr_ovr) | ovr_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RUN;
      a_s1_q      <= 1'b0;
      a_s2_q      <= 1'b0;
      a_prev_q    <= 1'b0;
      b_s1_q      <= 1'b0;
      b_s2_q      <= 1'b0;
      b_prev_q    <= 1'b0;
      timer_q     <= '0;
      cnt_q       <= '0;
      speed_q     <= '0;
      err_q       <= '0;
      err_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_s1_q      <= enc_a;
      a_s2_q      <= a_s1_q;
      a_prev_q    <= a_s2_q;
      b_s1_q      <= enc_b;
      b_s2_q      <= b_s1_q;
      b_prev_q    <= b_s2_q;
      timer_q     <= timer_d;
      cnt_q       <= cnt_d;
      speed_q     <= speed_d;
      err_q       <= err_d;
      err_valid_q <= err_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign speed            = speed_q;
  assign overrun          = overrun_q;
  assign err_if.err       = err_q;
  assign err_if.err_valid = err_valid_q;

endmodule

// File: tb/tb_pid_error_gen.sv
// Directed bench for pid_error_gen: table of steady encoder rates and
// setpoints, plus hand sequences for overrun, illegal steps and mid-window reset.
module tb_pid_error_gen;

  logic               clk = 1'b0;
  logic               rst;
  logic               enc_a, enc_b;
  logic signed [8:0]  setpoint;
  logic               clr_ovr;
  logic signed [15:0] speed;
  logic               overrun;

  pid_error_gen_if #(.ERR_W(9)) err_if ();

  pid_error_gen #(.SAMPLE_DIV(50), .CNT_W(16), .ERR_W(9), .DEADBAND(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .enc_a    (enc_a),
    .enc_b    (enc_b),
    .setpoint (setpoint),
    .clr_ovr  (clr_ovr),
    .speed    (speed),
    .overrun  (overrun),
    .err_if   (err_if)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int err_val();
    return int'($signed(err_if.err));
  endfunction

  // Encoder model: moves one Gray step every enc_period clocks, or holds manual_ab.
  int         enc_dir    = 0;
  int         enc_period = 5;
  logic [1:0] manual_ab  = 2'b00;

  function automatic logic [1:0] gray(input int p);
    case (p)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic int gray_idx(input logic [1:0] g);
    case (g)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  initial begin
    int pos = 0;
    int cnt = 0;
    enc_a = 1'b0;
    enc_b = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (enc_dir != 0) begin
        cnt++;
        if (cnt >= enc_period) begin
          cnt = 0;
          pos = (pos + enc_dir + 4) % 4;
        end
        {enc_a, enc_b} = gray(pos);
      end else begin
        pos = gray_idx(manual_ab);
        cnt = 0;
        {enc_a, enc_b} = manual_ab;
      end
    end
  end

  // Wait (bounded) for err_valid; returns at #1 after the edge that raised it.
  task automatic wait_sample(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk);
      #1;
      if (err_if.err_valid) got = 1'b1;
    end
    if (!got) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s: err_valid never rose within 200 clocks", name);
    end
  endtask

  task automatic stop_motion(input logic [1:0] ab);
    manual_ab = ab;
    enc_dir   = 0;
  endtask

  typedef struct {
    string name;
    int    dir;
    int    period;
    int    sp;
    int    exp_speed;
    int    exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    // Steady-state windows: 50 clocks / period edges each.
    vecs[0] = '{"idle",       0,  5,    0,   0,    0};
    vecs[1] = '{"fwd5_sp20",  1,  5,   20,  10,   10};
    vecs[2] = '{"rev5_sp-4", -1,  5,   -4, -10,    6};
    vecs[3] = '{"rev5_sp-256",-1, 5, -256, -10, -246};
    vecs[4] = '{"fwd1_satneg", 1, 1, -256,  50, -256};
    vecs[5] = '{"rev1_satpos",-1, 1,  255, -50,  255};
    vecs[6] = '{"fwd2_sp0",   1,  2,    0,  25,  -25};
`ifdef PID_ERR_DEADBAND_EN
    vecs[7] = '{"fwd25_db",   1, 25,    4,   2,    0};
`else
    vecs[7] = '{"fwd25_sp4",  1, 25,    4,   2,    2};
`endif

    rst       = 1'b1;
    setpoint  = '0;
    clr_ovr   = 1'b0;
    err_if.err_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_err",       err_val(),            0);
    check("reset_err_valid", int'(err_if.err_valid), 0);
    check("reset_speed",     int'(speed),          0);
    check("reset_overrun",   int'(overrun),        0);
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].dir == 0) begin
        stop_motion(2'b00);
      end else begin
        enc_period = vecs[v].period;
        enc_dir    = vecs[v].dir;
      end
      setpoint = 9'(vecs[v].sp);
      // First two samples may cover a window with the old rate.
      repeat (3) wait_sample(vecs[v].name);
      check({vecs[v].name, "_speed"},   int'(speed), vecs[v].exp_speed);
      check({vecs[v].name, "_err"},     err_val(),   vecs[v].exp_err);
      check({vecs[v].name, "_overrun"}, int'(overrun), 0);
    end

    // Overrun: hold err_ready low across two samples.
    enc_period = 5;
    enc_dir    = 1;
    setpoint   = 9'sd20;
    repeat (2) wait_sample("ovr_settle");
    err_if.err_ready = 1'b0;
    wait_sample("ovr_first");
    check("ovr_first_err", err_val(), 10);
    setpoint = 9'sd30;
    repeat (40) @(posedge clk);
    #1;
    check("ovr_hold_err",     err_val(),              10);
    check("ovr_hold_valid",   int'(err_if.err_valid), 1);
    check("ovr_hold_overrun", int'(overrun),          0);
    begin
      bit changed = 1'b0;
      for (int i = 0; i < 100 && !changed; i++) begin
        @(posedge clk);
        #1;
        if (err_val() != 10) changed = 1'b1;
      end
      check("ovr_overwritten", int'(changed), 1);
    end
    check("ovr_new_err",   err_val(),              20);
    check("ovr_new_valid", int'(err_if.err_valid), 1);
    check("ovr_sticky",    int'(overrun),          1);
    clr_ovr = 1'b1;
    @(posedge clk);
    #1;
    clr_ovr = 1'b0;
    check("ovr_cleared",     int'(overrun),          0);
    check("ovr_still_valid", int'(err_if.err_valid), 1);
    err_if.err_ready = 1'b1;
    @(posedge clk);
    #1;
    check("ovr_consumed", int'(err_if.err_valid), 0);

    // Illegal double transitions are ignored; one legal step counts.
    stop_motion(2'b00);
    setpoint = '0;
    repeat (2) wait_sample("ill_settle");
    check("ill_still_speed", int'(speed), 0);
    repeat (8) @(posedge clk);
    #1;
    manual_ab = 2'b11;
    repeat (8) @(posedge clk);
    #1;
    manual_ab = 2'b00;
    repeat (8) @(posedge clk);
    #1;
    manual_ab = 2'b01;
    wait_sample("ill_window");
    check("ill_speed", int'(speed), 1);
`ifdef PID_ERR_DEADBAND_EN
    check("ill_err", err_val(), 0);
`else
    check("ill_err", err_val(), -1);
`endif

    // Mid-window reset clears everything at once.
    repeat (20) @(posedge clk);
    #1;
    manual_ab = 2'b00;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mrst_err",     err_val(),              0);
    check("mrst_valid",   int'(err_if.err_valid), 0);
    check("mrst_speed",   int'(speed),            0);
    check("mrst_overrun", int'(overrun),          0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    begin
      // The clock cycle in which reset is released counts as clock 1.
      int  c   = 1;
      bit  got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
        @(posedge clk);
        #1;
        c++;
        if (err_if.err_valid) got = 1'b1;
      end
      check("mrst_latency", c, 52);
    end
    check("mrst_first_speed", int'(speed), 0);
    check("mrst_first_err",   err_val(),   0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
